// File: rtl/attack_score_tracker.sv
// -----------------------------------------------------------------------------
// attack_score_tracker
//   Score keeper for the attack phase of the battleship game. It consumes the
//   confirmed attack strobe, the selected coordinate and the ship bit of the
//   addressed map cell. It counts shots and distinct hits, rejects invalid or
//   already-shot coordinates, and closes the round on a win or a loss.
//
//   Build option: SHOT_REPEAT_PENALTY_EN
//     defined   : re-attacking a cell that was already shot still consumes a
//                 shot, so it can cause a loss.
//     undefined : re-attacking only raises result_repeat.
//
// Parameters
//   MAX_SHOTS  shots allowed per round (1..63)
//   COLS/ROWS  matrix size; valid coordinates are 0..COLS-1 / 0..ROWS-1
//
// Ports
//   clk               system (divided) clock
//   reset             synchronous, active-low
//   game_state_code   00 off, 01/11 preparation, 10 attack
//   attack_pulse      one-cycle confirmed attack strobe
//   x_coord_code      attack column
//   y_coord_code      attack row
//   cell_is_ship      ship bit of the addressed cell
//   ship_cells_total  ship cells in the selected map (captured in PREP)
//   shots_count       shots consumed this round
//   hits_count        distinct ship cells hit
//   shots_left        MAX_SHOTS - shots_count (0 while idle)
//   result_valid      one-cycle strobe, the attack has been resolved
//   result_hit        last result was a hit (held)
//   result_repeat     last result hit an already-shot cell (held)
//   game_over         round finished
//   game_won          round finished with every ship cell hit
// -----------------------------------------------------------------------------
module attack_score_tracker #(
  parameter int MAX_SHOTS = 20,
  parameter int COLS      = 7,
  parameter int ROWS      = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] game_state_code,
  input  logic       attack_pulse,
  input  logic [2:0] x_coord_code,
  input  logic [2:0] y_coord_code,
  input  logic       cell_is_ship,
  input  logic [5:0] ship_cells_total,
  output logic [5:0] shots_count,
  output logic [5:0] hits_count,
  output logic [5:0] shots_left,
  output logic       result_valid,
  output logic       result_hit,
  output logic       result_repeat,
  output logic       game_over,
  output logic       game_won
);

  localparam int         CELLS       = COLS * ROWS;
  localparam int         IW          = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam logic [5:0] MAX_SHOTS_W = 6'(MAX_SHOTS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PREP = 2'd1;
  localparam logic [1:0] ST_PLAY = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  logic [1:0]       state;
  logic [CELLS-1:0] shot_map;
  logic [5:0]       target;

  logic          coord_ok;
  logic [IW-1:0] cell_idx;
  logic          cell_shot;
  logic          win_now;
  logic          lose_now;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  // Coordinate decode and end-of-round detection. The end conditions look at
  // the registered counters, so they fire the cycle after the deciding
  // result is presented and the round closes one edge later.
  always_comb begin
    coord_ok  = (int'(x_coord_code) < COLS) && (int'(y_coord_code) < ROWS);
    // Invalid coordinates are steered to cell 0; the value is never used.
    cell_idx  = coord_ok ? IW'(int'(y_coord_code) * COLS + int'(x_coord_code)) : '0;
    cell_shot = shot_map[cell_idx];
    // An empty fleet can never be won; such a round only ends by losing.
    win_now   = (target != 6'd0) && (hits_count == target);
    lose_now  = !win_now && (shots_count >= MAX_SHOTS_W);
  end

  assign shots_left = (state == ST_IDLE) ? 6'd0 : MAX_SHOTS_W - shots_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= ST_IDLE;
      shot_map      <= '0;
      target        <= '0;
      shots_count   <= '0;
      hits_count    <= '0;
      result_valid  <= 1'b0;
      result_hit    <= 1'b0;
      result_repeat <= 1'b0;
      game_over     <= 1'b0;
      game_won      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      // The game code is decoded first: a code change wins over any attack
      // presented in the same cycle.
      case (game_state_code)
        2'b00: begin
          state         <= ST_IDLE;
          shot_map      <= '0;
          target        <= '0;
          shots_count   <= '0;
          hits_count    <= '0;
          result_hit    <= 1'b0;
          result_repeat <= 1'b0;
          game_over     <= 1'b0;
          game_won      <= 1'b0;
        end
        2'b01, 2'b11: begin
          // Preparation keeps the round fresh every cycle and tracks the
          // currently selected map until play starts.
          state         <= ST_PREP;
          shot_map      <= '0;
          target        <= ship_cells_total;
          shots_count   <= '0;
          hits_count    <= '0;
          result_hit    <= 1'b0;
          result_repeat <= 1'b0;
          game_over     <= 1'b0;
          game_won      <= 1'b0;
        end
        default: begin
          case (state)
            ST_PREP: state <= ST_PLAY;
            ST_PLAY: begin
              if (win_now || lose_now) begin
                // Pulses arriving while the round is closing are dropped.
                state     <= ST_OVER;
                game_over <= 1'b1;
                game_won  <= win_now;
              end else if (attack_pulse) begin
                result_valid <= 1'b1;
                if (!coord_ok) begin
                  result_hit    <= 1'b0;
                  result_repeat <= 1'b0;
                end else if (cell_shot) begin
                  result_hit    <= 1'b0;
                  result_repeat <= 1'b1;
`ifdef SHOT_REPEAT_PENALTY_EN
                  shots_count   <= sat_inc(shots_count);
`endif
                end else begin
                  shot_map[cell_idx] <= 1'b1;
                  shots_count        <= sat_inc(shots_count);
                  result_repeat      <= 1'b0;
                  result_hit         <= cell_is_ship;
                  if (cell_is_ship) hits_count <= sat_inc(hits_count);
                end
              end
            end
            // IDLE waits for preparation; OVER holds everything.
            default: state <= state;
          endcase
        end
      endcase
    end
  end

  // A round closes as soon as the shot budget is used up.
  a_shots_bounded: assert property (@(posedge clk) disable iff (!reset)
    shots_count <= MAX_SHOTS_W);

endmodule

// File: tb/tb_attack_score_tracker.sv
module tb_attack_score_tracker;
  localparam int MS = 20, MS4 = 4, COLS = 7, ROWS = 5;
  localparam int M_IDLE = 0, M_PREP = 1, M_PLAY = 2, M_OVER = 3;

  logic       clk = 1'b0, reset = 1'b0;
  logic [1:0] code = 2'b10;
  logic       pulse = 1'b0, ship = 1'b0;
  logic [2:0] x = '0, y = '0;
  logic [5:0] total = '0;
  logic [5:0] sc, hc, sl, sc4, hc4, sl4;
  logic       rv, rh, rr, go, gw, rv4, rh4, rr4, go4, gw4;

  always #5 clk = ~clk;

  attack_score_tracker #(.MAX_SHOTS(MS), .COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .game_state_code(code), .attack_pulse(pulse),
    .x_coord_code(x), .y_coord_code(y), .cell_is_ship(ship), .ship_cells_total(total),
    .shots_count(sc), .hits_count(hc), .shots_left(sl), .result_valid(rv),
    .result_hit(rh), .result_repeat(rr), .game_over(go), .game_won(gw));

  attack_score_tracker #(.MAX_SHOTS(MS4), .COLS(COLS), .ROWS(ROWS)) dut4 (
    .clk(clk), .reset(reset), .game_state_code(code), .attack_pulse(pulse),
    .x_coord_code(x), .y_coord_code(y), .cell_is_ship(ship), .ship_cells_total(total),
    .shots_count(sc4), .hits_count(hc4), .shots_left(sl4), .result_valid(rv4),
    .result_hit(rh4), .result_repeat(rr4), .game_over(go4), .game_won(gw4));

  typedef struct packed {
    logic       hit;
    logic       rep;
    logic [5:0] shots;
    logic [5:0] hits;
    logic [5:0] left;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;

  // Reference model: a round in plain terms
  int m_state = M_IDLE;
  int m_shots = 0, m_hits = 0, m_target = 0;
  bit shot[64];
  bit board[64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every presented result is matched with the oldest expected one.
  always @(negedge clk) begin
    exp_t e;
    if (reset && rv === 1'b1) begin
      if (q.size() == 0) chk("unexpected_result_valid", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("result_hit", 32'(rh), 32'(e.hit));
        chk("result_repeat", 32'(rr), 32'(e.rep));
        chk("shots_count", 32'(sc), 32'(e.shots));
        chk("hits_count", 32'(hc), 32'(e.hits));
        chk("shots_left", 32'(sl), 32'(e.left));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_round();
    m_shots = 0;
    m_hits  = 0;
    for (int i = 0; i < 64; i++) shot[i] = 1'b0;
  endtask

  task automatic set_code(input logic [1:0] c, input int n);
    code = c;
    if (c == 2'b00) begin
      m_state = M_IDLE; m_target = 0; clear_round();
    end else if (c[0]) begin
      m_state = M_PREP; m_target = int'(total); clear_round();
    end else if (m_state == M_PREP) begin
      m_state = M_PLAY;
    end
    repeat (n) tick();
  endtask

  task automatic set_board(input int k);
    int c;
    for (int i = 0; i < 64; i++) board[i] = 1'b0;
    for (int i = 0; i < k; i++) begin
      do c = $urandom_range(0, COLS * ROWS - 1); while (board[c]);
      board[c] = 1'b1;
    end
    total = 6'(k);
  endtask

  task automatic attack(input int xi, input int yi);
    exp_t e;
    bit   ok, s, ended, won;
    int   k;
    ended = 1'b0; won = 1'b0;
    ok = (xi < COLS) && (yi < ROWS);
    k  = yi * COLS + xi;
    s  = ok ? board[k] : 1'($urandom_range(0, 1));
    x = 3'(xi); y = 3'(yi); ship = s; pulse = 1'b1;
    if (m_state == M_PLAY) begin
      e.hit = 1'b0; e.rep = 1'b0;
      if (ok && shot[k]) begin
        e.rep = 1'b1;
`ifdef SHOT_REPEAT_PENALTY_EN
        if (m_shots < 63) m_shots++;
`endif
      end else if (ok) begin
        shot[k] = 1'b1;
        if (m_shots < 63) m_shots++;
        if (s) begin
          e.hit = 1'b1;
          if (m_hits < 63) m_hits++;
        end
      end
      e.shots = 6'(m_shots); e.hits = 6'(m_hits); e.left = 6'(MS - m_shots);
      q.push_back(e);
      won   = (m_target != 0) && (m_hits == m_target);
      ended = won || (m_shots >= MS);
    end
    tick();
    pulse = 1'b0;
    if (ended) begin
      chk("game_over_early", 32'(go), 32'd0);
      tick();
      chk("game_over", 32'(go), 32'd1);
      chk("game_won", 32'(gw), 32'(won));
      m_state = M_OVER;
    end
  endtask

  initial begin
    // 1. reset while code=10, then stay idle
    repeat (2) tick();
    chk("rst_shots", 32'(sc), 32'd0);
    chk("rst_hits", 32'(hc), 32'd0);
    chk("rst_left", 32'(sl), 32'd0);
    chk("rst_flags", {27'd0, rv, rh, rr, go, gw}, 32'd0);
    reset = 1'b1;
    repeat (3) tick();
    attack(1, 1);
    tick();
    chk("idle_left", 32'(sl), 32'd0);
    chk("idle_shots", 32'(sc), 32'd0);
    chk("idle_over", 32'(go), 32'd0);

    // 2..5. directed round, fleet at (0,0),(1,1),(2,2)
    for (int i = 0; i < 64; i++) board[i] = 1'b0;
    board[0] = 1'b1; board[1 * COLS + 1] = 1'b1; board[2 * COLS + 2] = 1'b1;
    total = 6'd3;
    set_code(2'b01, 2);
    chk("prep_left", 32'(sl), 32'(MS));
    set_code(2'b10, 1);
    attack(0, 0);
    attack(7, 2);
    attack(0, 5);
    attack(0, 0);
    tick();
    attack(1, 1);
    attack(2, 2);
    attack(3, 3);
    repeat (2) tick();
    chk("over_held", 32'(go), 32'd1);

    // 6. shot budget of 4 on the second instance: four misses
    for (int i = 0; i < 64; i++) board[i] = 1'b0;
    board[4 * COLS + 0] = 1'b1; board[4 * COLS + 1] = 1'b1; board[4 * COLS + 2] = 1'b1;
    total = 6'd3;
    set_code(2'b11, 2);
    set_code(2'b10, 1);
    for (int i = 0; i < 4; i++) attack(i, 0);
    tick();
    chk("lose4_over", 32'(go4), 32'd1);
    chk("lose4_won", 32'(gw4), 32'd0);
    chk("lose4_left", 32'(sl4), 32'd0);
    chk("lose4_shots", 32'(sc4), 32'd4);
    set_code(2'b01, 2);
    chk("prep4_left", 32'(sl4), 32'(MS4));
    chk("prep4_shots", 32'(sc4), 32'd0);
    chk("prep4_over", 32'(go4), 32'd0);

    // randomized rounds, including empty fleets and invalid coordinates
    for (int r = 0; r < 12; r++) begin
      set_code(2'b00, 1 + $urandom_range(0, 1));
      set_board($urandom_range(0, 5));
      set_code($urandom_range(0, 1) ? 2'b01 : 2'b11, 2);
      set_code(2'b10, 1);
      for (int i = 0; i < 40; i++) begin
        attack($urandom_range(0, 7), $urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) tick();
      end
    end

    repeat (3) tick();
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
